// File: rtl/disp_mode_ctrl.sv
// Display mode / field-edit controller: walks the view and SET modes, schedules
// inc/dec commands away from the seconds carry, and feeds the selected word to hex8.
module disp_mode_ctrl #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned BLINK_HZ       = 2,
  parameter int unsigned IDLE_TIMEOUT_S = 10,
  parameter logic [3:0]  BLANK_NIBBLE   = 4'hF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  Key_P_flag,
  input  logic        Sec_Tick,
  input  logic [31:0] Clock_Data,
  input  logic [31:0] Calendar_Data,
  input  logic [31:0] Alarm_Data,
  input  logic [31:0] Timer_Data,
  output logic [2:0]  Mode,
  output logic        Edit_En,
  output logic [1:0]  Field_Sel,
  output logic        Inc_Pulse,
  output logic        Dec_Pulse,
  output logic        Timer_Run,
  output logic        Timer_Clr,
  output logic [31:0] Disp_Data
);

  localparam logic [2:0] CLOCK     = 3'd0;
  localparam logic [2:0] CLOCK_SET = 3'd1;
  localparam logic [2:0] CALENDAR  = 3'd2;
  localparam logic [2:0] CAL_SET   = 3'd3;
  localparam logic [2:0] ALARM     = 3'd4;
  localparam logic [2:0] ALARM_SET = 3'd5;
  localparam logic [2:0] TIMER     = 3'd6;

  localparam int unsigned HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int BW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
  localparam int IW = (IDLE_TIMEOUT_S > 1) ? $clog2(IDLE_TIMEOUT_S + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_S - 1);

  logic [2:0]    mode_q, mode_d;
  logic          edit_en_q, edit_en_d;
  logic [1:0]    field_q, field_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          pend_q, pend_d, pend_dec_q, pend_dec_d;
  logic          run_q, run_d, clr_q, clr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [31:0]   disp_q, disp_d;
  logic [3:0]    key_s;
  logic          any_key_s, set_mode_s, issue_s;

  assign any_key_s  = |Key_P_flag;
  assign set_mode_s = mode_q[0] & (mode_q != 3'd7);
  // A held request goes out on the first non-tick cycle unless a mode change discards it.
  assign issue_s    = pend_q & ~Sec_Tick & ~key_s[3];

  // Only the highest-priority key of a cycle survives.
  always_comb begin
    key_s = 4'b0000;
    if (Key_P_flag[3])      key_s = 4'b1000;
    else if (Key_P_flag[2]) key_s = 4'b0100;
    else if (Key_P_flag[1]) key_s = 4'b0010;
    else if (Key_P_flag[0]) key_s = 4'b0001;
    else                    key_s = 4'b0000;
  end

  // Mode state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) mode_q <= CLOCK;
    else          mode_q <= mode_d;
  end

  // Mode next-state: Key3 advances; idle timeout drops a SET mode back to its view mode.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      CLOCK, CLOCK_SET, CALENDAR, CAL_SET, ALARM, ALARM_SET: begin
        if (key_s[3]) mode_d = mode_q + 3'd1;
        else if (set_mode_s && !any_key_s && Sec_Tick && (idle_q == IDLE_LAST)) mode_d = mode_q - 3'd1;
        else mode_d = mode_q;
      end
      TIMER: begin
        if (key_s[3]) mode_d = CLOCK;
        else          mode_d = TIMER;
      end
      default: mode_d = CLOCK;
    endcase
  end

  // Next values for every registered output and the edit bookkeeping.
  always_comb begin
    edit_en_d   = mode_d[0] & (mode_d != 3'd7);
    field_d     = field_q;
    idle_d      = idle_q;
    pend_d      = pend_q;
    pend_dec_d  = pend_dec_q;
    run_d       = run_q;
    clr_d       = 1'b0;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    disp_d      = 32'h0000_0000;

    if (!edit_en_d || (mode_d != mode_q)) field_d = 2'd0;
    else if (key_s[2])                    field_d = (field_q >= 2'd2) ? 2'd0 : field_q + 2'd1;
    else                                  field_d = field_q;

    if (!edit_en_d || (mode_d != mode_q) || any_key_s) idle_d = '0;
    else if (Sec_Tick)                                 idle_d = idle_q + IW'(1);
    else                                               idle_d = idle_q;

    if (key_s[3])      pend_d = 1'b0;
    else if (pend_q)   pend_d = ~issue_s;
    else if (set_mode_s && (key_s[1] || key_s[0])) begin
      pend_d     = 1'b1;
      pend_dec_d = key_s[0];
    end else           pend_d = 1'b0;

    if (mode_q == TIMER) begin
      if (key_s[1])      run_d = ~run_q;
      else if (key_s[0]) begin
        run_d = 1'b0;
        clr_d = 1'b1;
      end else           run_d = run_q;
    end else             run_d = run_q;

    if (blink_cnt_q == HALF_M1) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      phase_d     = phase_q;
    end
    if (set_mode_s && any_key_s) phase_d = 1'b0;
    else                         phase_d = phase_d;

    case (mode_q)
      CLOCK, CLOCK_SET:   disp_d = Clock_Data;
      CALENDAR, CAL_SET:  disp_d = Calendar_Data;
      ALARM, ALARM_SET:   disp_d = Alarm_Data;
      TIMER:              disp_d = Timer_Data;
      default:            disp_d = 32'h0000_0000;
    endcase
    // Point nibbles [23:20] and [11:8] stay lit while a field blinks.
    if (edit_en_q && phase_q) begin
      case (field_q)
        2'd0:    disp_d[31:24] = {BLANK_NIBBLE, BLANK_NIBBLE};
        2'd1:    disp_d[19:12] = {BLANK_NIBBLE, BLANK_NIBBLE};
        2'd2:    disp_d[7:0]   = {BLANK_NIBBLE, BLANK_NIBBLE};
        default: disp_d        = disp_d;
      endcase
    end else begin
      disp_d = disp_d;
    end
  end

  // Edit, scheduling, timer, blink and display registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      edit_en_q   <= 1'b0;
      field_q     <= 2'd0;
      idle_q      <= '0;
      pend_q      <= 1'b0;
      pend_dec_q  <= 1'b0;
      run_q       <= 1'b0;
      clr_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      disp_q      <= 32'h0000_0000;
    end else begin
      edit_en_q   <= edit_en_d;
      field_q     <= field_d;
      idle_q      <= idle_d;
      pend_q      <= pend_d;
      pend_dec_q  <= pend_dec_d;
      run_q       <= run_d;
      clr_q       <= clr_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      disp_q      <= disp_d;
    end
  end

  assign Mode      = mode_q;
  assign Edit_En   = edit_en_q;
  assign Field_Sel = field_q;
  assign Inc_Pulse = issue_s & ~pend_dec_q;
  assign Dec_Pulse = issue_s & pend_dec_q;
  assign Timer_Run = run_q;
  assign Timer_Clr = clr_q;
  assign Disp_Data = disp_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed bench for disp_mode_ctrl; command pulses are checked against a queue of expected events.
module tb_disp_mode_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  Key_P_flag;
  logic        Sec_Tick;
  logic [31:0] Clock_Data, Calendar_Data, Alarm_Data, Timer_Data;
  logic [2:0]  Mode;
  logic        Edit_En, Inc_Pulse, Dec_Pulse, Timer_Run, Timer_Clr;
  logic [1:0]  Field_Sel;
  logic [31:0] Disp_Data;

  localparam logic [31:0] CLK_W = 32'h12A34A56;
  localparam logic [31:0] CAL_W = 32'h24A06A15;
  localparam logic [31:0] ALM_W = 32'h00A30A07;
  localparam logic [31:0] TMR_W = 32'h00A05A30;
  localparam logic [31:0] HID_W = 32'h12AFFA56;
  localparam logic [2:0]  K_INC = 3'b100;
  localparam logic [2:0]  K_DEC = 3'b010;
  localparam logic [2:0]  K_CLR = 3'b001;

  typedef struct { logic [2:0] kind; int at; } ev_t;
  ev_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  disp_mode_ctrl #(.CLK_HZ(8), .BLINK_HZ(1), .IDLE_TIMEOUT_S(10), .BLANK_NIBBLE(4'hF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Key_P_flag(Key_P_flag), .Sec_Tick(Sec_Tick),
    .Clock_Data(Clock_Data), .Calendar_Data(Calendar_Data), .Alarm_Data(Alarm_Data),
    .Timer_Data(Timer_Data), .Mode(Mode), .Edit_En(Edit_En), .Field_Sel(Field_Sel),
    .Inc_Pulse(Inc_Pulse), .Dec_Pulse(Dec_Pulse), .Timer_Run(Timer_Run),
    .Timer_Clr(Timer_Clr), .Disp_Data(Disp_Data)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    Key_P_flag = k;
    step();
    Key_P_flag = 4'd0;
  endtask

  task automatic sec();
    Sec_Tick = 1'b1;
    step();
    Sec_Tick = 1'b0;
    step();
  endtask

  task automatic expect_pulse(input logic [2:0] k, input int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Pulse monitor: every command pulse must match the next queued event.
  always @(negedge Clk) begin
    ev_t e;
    if (Reset_n === 1'b1) begin
      if (Sec_Tick) chk("no_pulse_on_tick", {30'd0, Inc_Pulse, Dec_Pulse}, 32'd0);
      if (Inc_Pulse || Dec_Pulse || Timer_Clr) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {29'd0, Inc_Pulse, Dec_Pulse, Timer_Clr}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {29'd0, Inc_Pulse, Dec_Pulse, Timer_Clr}, {29'd0, e.kind});
          chk("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  em;
    logic [31:0] ed, prev;
    logic        found;
    int          c;

    Reset_n = 1'b0; Key_P_flag = 4'd0; Sec_Tick = 1'b0;
    Clock_Data = CLK_W; Calendar_Data = CAL_W; Alarm_Data = ALM_W; Timer_Data = TMR_W;
    step(); step();
    chk("rst_mode", {29'd0, Mode}, 32'd0);
    chk("rst_outs", {26'd0, Edit_En, Field_Sel, Inc_Pulse, Dec_Pulse, Timer_Run, Timer_Clr}, 32'd0);
    chk("rst_disp", Disp_Data, 32'd0);
    Reset_n = 1'b1;
    step();
    chk("disp_clock", Disp_Data, CLK_W);

    // Full mode ring, 4 cycles per press.
    for (int i = 0; i < 7; i++) begin
      press(4'b1000);
      repeat (3) step();
      em = 3'((i + 1) % 7);
      chk("mode_seq", {29'd0, Mode}, {29'd0, em});
      chk("edit_seq", {31'd0, Edit_En}, {31'd0, em[0]});
      case (em)
        3'd2:    ed = CAL_W;
        3'd4:    ed = ALM_W;
        3'd6:    ed = TMR_W;
        default: ed = CLK_W;
      endcase
      if (!em[0]) chk("disp_seq", Disp_Data, ed);
    end

    // CLOCK_SET: field stepping and a plain increment.
    press(4'b1000);
    press(4'b0100);
    press(4'b0100);
    chk("field_2", {30'd0, Field_Sel}, 32'd2);
    expect_pulse(K_INC, cyc + 1);
    press(4'b0010);
    step();
    press(4'b0100);
    press(4'b0100);
    chk("field_1", {30'd0, Field_Sel}, 32'd1);

    // Blink: find a visible->hidden edge, then expect 4-cycle alternation.
    found = 1'b0;
    prev  = Disp_Data;
    for (int i = 0; i < 12; i++) begin
      if (!found) begin
        step();
        if (prev == CLK_W && Disp_Data == HID_W) found = 1'b1;
        prev = Disp_Data;
      end
    end
    chk("blink_found", {31'd0, found}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("blink_word", Disp_Data, (((i / 4) % 2) == 0) ? HID_W : CLK_W);
      step();
    end

    // Decrement flagged one cycle before the tick goes out after it.
    c = cyc;
    expect_pulse(K_DEC, c + 2);
    Key_P_flag = 4'b0001; step();
    Key_P_flag = 4'b0000; Sec_Tick = 1'b1; step();
    Sec_Tick = 1'b0; step(); step();

    // Second request while one is held is dropped.
    c = cyc;
    expect_pulse(K_INC, c + 2);
    Key_P_flag = 4'b0010; step();
    Key_P_flag = 4'b0001; Sec_Tick = 1'b1; step();
    Key_P_flag = 4'b0000; Sec_Tick = 1'b0; step(); step();

    // Held request discarded by Key3.
    Key_P_flag = 4'b0010; step();
    Key_P_flag = 4'b1000; Sec_Tick = 1'b1; step();
    Key_P_flag = 4'b0000; Sec_Tick = 1'b0; step();
    chk("discard_mode", {29'd0, Mode}, 32'd2);

    // CAL_SET idle timeout, restarted by a key after tick 9.
    press(4'b1000);
    chk("calset_mode", {29'd0, Mode}, 32'd3);
    repeat (9) sec();
    chk("tick9_mode", {29'd0, Mode}, 32'd3);
    expect_pulse(K_INC, cyc + 1);
    press(4'b0010);
    step();
    repeat (9) sec();
    chk("restart_mode", {29'd0, Mode}, 32'd3);
    sec();
    chk("timeout_mode", {29'd0, Mode}, 32'd2);
    chk("timeout_edit", {31'd0, Edit_En}, 32'd0);
    chk("timeout_disp", Disp_Data, CAL_W);

    // TIMER run/clear control.
    repeat (4) press(4'b1000);
    step();
    chk("timer_mode", {29'd0, Mode}, 32'd6);
    chk("timer_disp", Disp_Data, TMR_W);
    press(4'b0010);
    chk("run_on", {31'd0, Timer_Run}, 32'd1);
    expect_pulse(K_CLR, cyc + 1);
    press(4'b0001);
    chk("run_cleared", {31'd0, Timer_Run}, 32'd0);
    step();
    press(4'b0011);
    chk("run_toggle_only", {31'd0, Timer_Run}, 32'd1);
    step();
    press(4'b1000);
    chk("leave_timer_mode", {29'd0, Mode}, 32'd0);
    chk("run_kept", {31'd0, Timer_Run}, 32'd1);
    step(); step();
    chk("sb_empty", sb.size(), 32'd0);

    // Asynchronous reset mid-operation.
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_mode", {29'd0, Mode}, 32'd0);
    chk("arst_run", {31'd0, Timer_Run}, 32'd0);
    chk("arst_disp", Disp_Data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
